// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding memory fetch feeding a small
// instruction buffer toward decode, with redirect flush and fault halt.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } entry_t;

  state_t             state, state_n;
  logic [31:0]        fetch_pc, fetch_pc_n;
  logic [CNT_W-1:0]   count, cnt_after;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  entry_t             buf_q [DEPTH];
  entry_t             head;
  logic               hs, push, pop;

  // Handshake, buffer push/pop qualifiers; redirect overrides both
  always_comb begin
    hs        = (state == REQ) & mem_req_ready;
    push      = (state == WAIT) & mem_resp_valid & ~redirect_valid;
    pop       = (count != '0) & inst_ready & ~redirect_valid;
    cnt_after = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
  end

  // Next-state and next fetch address
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    case (state)
      IDLE:  if (count < CNT_W'(DEPTH)) state_n = REQ;
      REQ:   if (hs) state_n = WAIT;
      WAIT: begin
        if (mem_resp_valid) begin
          if (mem_resp_err) begin
            state_n = HALT;
          end else begin
            fetch_pc_n = fetch_pc + 32'd4;
            state_n    = (cnt_after < CNT_W'(DEPTH)) ? REQ : IDLE;
          end
        end
      end
      DRAIN: if (mem_resp_valid) state_n = REQ;
      HALT:  state_n = HALT;
      default: state_n = IDLE;
    endcase
    // A redirect wins; an in-flight request must still be drained
    if (redirect_valid) begin
      fetch_pc_n = redirect_pc & 32'hFFFF_FFFC;
      case (state)
        REQ:     state_n = hs ? DRAIN : REQ;
        WAIT:    state_n = mem_resp_valid ? REQ : DRAIN;
        DRAIN:   state_n = mem_resp_valid ? REQ : DRAIN;
        default: state_n = REQ;
      endcase
    end
  end

  // State and fetch address registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
    end
  end

  // Buffer occupancy and pointers; redirect flushes
  always_ff @(posedge clk) begin
    if (!reset || redirect_valid) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= cnt_after;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Buffer storage; contents only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= '{pc: fetch_pc, data: mem_resp_data, err: mem_resp_err};
  end

  assign head          = buf_q[rd_ptr];
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = fetch_pc;
  assign inst_valid    = (count != '0);
  assign inst          = head.data;
  assign inst_pc       = head.pc;
  assign inst_err      = inst_valid & head.err;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a one-cycle-latency memory model.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready, inst_err;
  logic [31:0] inst, inst_pc;

  ifu_fetch #(.RESET_PC(32'h8000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] req_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_data_q[$];
  logic        pop_err_q[$];
  bit          mem_hold, err_en, pend;
  logic [31:0] err_addr, pend_addr;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One clock: log handshakes/pops, then play the memory model
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    hs = reset && mem_req_valid && mem_req_ready;
    a  = mem_req_addr;
    if (hs) req_q.push_back(a);
    if (reset && inst_valid && inst_ready && !redirect_valid) begin
      pop_pc_q.push_back(inst_pc);
      pop_data_q.push_back(inst);
      pop_err_q.push_back(inst_err);
    end
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    if (hs) begin
      pend      = 1'b1;
      pend_addr = a;
    end
    if (pend && !mem_hold) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = ~pend_addr;
      mem_resp_err   = err_en && (pend_addr == err_addr);
      pend           = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    req_q.delete();
    pop_pc_q.delete();
    pop_data_q.delete();
    pop_err_q.delete();
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    pend           = 1'b0;
    mem_hold       = 1'b0;
    err_en         = 1'b0;
    ticks(2);
    pend           = 1'b0;
    check32("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check32("rst_inst_valid", 32'(inst_valid), 32'd0);
    check32("rst_inst_err", 32'(inst_err), 32'd0);
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic check_req(input string tag, input int idx, input logic [31:0] addr);
    if (req_q.size() > idx) check32(tag, req_q[idx], addr);
    else check32({tag, "_missing"}, 32'(req_q.size()), 32'(idx + 1));
  endtask

  task automatic check_pop(input string tag, input int idx, input logic [31:0] pc, input logic err);
    if (pop_pc_q.size() > idx) begin
      check32({tag, "_pc"}, pop_pc_q[idx], pc);
      check32({tag, "_data"}, pop_data_q[idx], ~pc);
      check32({tag, "_err"}, 32'(pop_err_q[idx]), 32'(err));
    end else begin
      check32({tag, "_missing"}, 32'(pop_pc_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
    inst_ready = 1'b1; err_addr = '0; pend_addr = '0;

    // Streaming fetch from reset
    do_reset();
    tick();
    check32("first_req_valid", 32'(mem_req_valid), 32'd1);
    check32("first_req_addr", mem_req_addr, 32'h8000_0000);
    ticks(12);
    check_pop("s0", 0, 32'h8000_0000, 1'b0);
    check_pop("s1", 1, 32'h8000_0004, 1'b0);
    check_pop("s2", 2, 32'h8000_0008, 1'b0);

    // Backpressure: buffer full stops requests
    inst_ready = 1'b0;
    do_reset();
    ticks(20);
    check32("full_req_count", 32'(req_q.size()), 32'd2);
    check32("full_req_valid", 32'(mem_req_valid), 32'd0);
    check32("full_head_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1'b1;
    req_q.delete();
    for (int i = 0; i < 10 && req_q.size() == 0; i++) tick();
    check_req("resume_addr", 0, 32'h8000_0008);

    // Redirect while waiting without response
    do_reset();
    mem_hold = 1'b1;
    ticks(2);
    check32("wait_req_count", 32'(req_q.size()), 32'd1);
    redirect(32'h8000_1003);
    check32("drain_req_valid", 32'(mem_req_valid), 32'd0);
    check32("drain_inst_valid", 32'(inst_valid), 32'd0);
    clear_logs();
    mem_hold = 1'b0;
    tick();
    check32("drain_resp_req_valid", 32'(mem_req_valid), 32'd0);
    tick();
    check32("post_drain_addr", mem_req_addr, 32'h8000_1000);
    check32("post_drain_valid", 32'(mem_req_valid), 32'd1);
    ticks(8);
    check_req("redir_req", 0, 32'h8000_1000);
    check_pop("redir_pop", 0, 32'h8000_1000, 1'b0);
    bad = 0;
    foreach (pop_pc_q[i]) if (pop_pc_q[i][31:12] != 20'h80001) bad++;
    check32("stale_entries", 32'(bad), 32'd0);

    // Access fault halts fetch until redirect
    do_reset();
    err_en   = 1'b1;
    err_addr = 32'h8000_0004;
    ticks(15);
    check32("fault_req_count", 32'(req_q.size()), 32'd2);
    check32("fault_req_valid", 32'(mem_req_valid), 32'd0);
    check_pop("f0", 0, 32'h8000_0000, 1'b0);
    check_pop("f1", 1, 32'h8000_0004, 1'b1);
    clear_logs();
    redirect(32'h8000_0100);
    ticks(8);
    check_req("halt_resume", 0, 32'h8000_0100);
    check_pop("halt_pop", 0, 32'h8000_0100, 1'b0);

    // Address wrap and stalled request stability
    mem_req_ready = 1'b0;
    do_reset();
    tick();
    redirect(32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) begin
      check32("stall_valid", 32'(mem_req_valid), 32'd1);
      check32("stall_addr", mem_req_addr, 32'hFFFF_FFFC);
      tick();
    end
    mem_req_ready = 1'b1;
    ticks(10);
    check_req("wrap_req0", 0, 32'hFFFF_FFFC);
    check_req("wrap_req1", 1, 32'h0000_0000);
    check_pop("wrap_pop0", 0, 32'hFFFF_FFFC, 1'b0);
    check_pop("wrap_pop1", 1, 32'h0000_0000, 1'b0);

    // Reset mid-WAIT; late response must be ignored
    do_reset();
    mem_hold = 1'b1;
    ticks(2);
    check32("pre_rst_req_count", 32'(req_q.size()), 32'd1);
    do_reset();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    tick();
    check32("late_resp_inst_valid", 32'(inst_valid), 32'd0);
    check32("late_resp_req_valid", 32'(mem_req_valid), 32'd1);
    check32("late_resp_req_addr", mem_req_addr, 32'h8000_0000);
    ticks(6);
    check_pop("late_pop0", 0, 32'h8000_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
